riscv_wb: RTL
=============

// Module: riscv_wb
// PURPOSE
//  Writeback stage, directly downstream of the MEM stage. Accepts one retiring instruction per handshake:
//  - ALU result: written to the register file 1 cycle after accept.
//  - Load: waits for the data-bus read response, aligns and extends it, then writes the register file.
//  Also provides pending-destination info for hazard logic, plus sticky/pulsed error flags.
// PARAMETERS
//  LD_FUNCT_W  3   width of load-function code
//  TIMEOUT     64  max WAIT cycles for a read response (>=2)
// PORTS
//  clk             in   1   clock
//  rstn            in   1   async active-low reset
//  mem_wb_vld      in   1   MEM stage presents an instruction
//  mem_wb_rdy      out  1   WB can accept (high only in IDLE)
//  mem_wb_funct    in   3   0 NOP(ALU/store) 1 LB 2 LH 3 LW 4 LBU 5 LHU, 6-7 treated as NOP
//  mem_wb_baddr    in   2   byte offset of load address
//  mem_wb_data     in   32  ALU result (used when funct=NOP)
//  mem_wb_rsd      in   5   destination register; 0 = no write
//  data_bif_rvalid in   1   read response valid
//  data_bif_rdata  in   32  read response word (word-aligned)
//  rf_wen          out  1   register-file write strobe (1-cycle pulse)
//  rf_waddr        out  5   register-file write address
//  rf_wdata        out  32  register-file write data
//  wb_pend_vld     out  1   load outstanding (state WAIT)
//  wb_pend_rsd     out  5   destination of outstanding load
//  err_misalign    out  1   1-cycle pulse: misaligned load accepted
//  err_timeout     out  1   1-cycle pulse: response timeout
//  err_spurious    out  1   sticky: rvalid with no load outstanding
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0. All outputs 0 except mem_wb_rdy=1. Pending load discarded.
//  - A response arriving after reset is spurious.
//  Handshake: accept = mem_wb_vld & mem_wb_rdy; mem_wb_rdy = (state==IDLE), combinational from state.
//  IDLE, accept NOP:
//  - rf_wen<=(rsd!=0), rf_waddr<=rsd, rf_wdata<=mem_wb_data.
//  - Registered, so visible the cycle after accept.
//  IDLE, accept load:
//  - Latch funct/baddr/rsd. If data_bif_rvalid in the same cycle, it completes the load at once (no WAIT).
//  - Otherwise go to WAIT with cnt=0.
//  Misalign check:
//  - Misaligned: LH/LHU with baddr[0]=1; LW with baddr!=0.
//  - Misaligned load: err_misalign pulses next cycle, no WAIT, no rf write. The response still arrives and flags err_spurious.
//  WAIT:
//  - wb_pend_vld=1, wb_pend_rsd=latched rsd. cnt increments each cycle.
//  - rvalid: complete, ->IDLE.
//  - Else cnt==TIMEOUT-1: err_timeout pulse, no rf write, ->IDLE.
//  - rvalid on the timeout cycle: completes normally, no error.
//  Completion (either path): rf_wen<=(rsd!=0), rf_waddr<=rsd, and rf_wdata as follows:
//  - b = rdata byte at baddr (bits 8*baddr+7:8*baddr); h = rdata half at baddr[1] (bits 16*baddr[1]+15:16*baddr[1]).
//  - LB {{24{b[7]}},b}; LBU {24'b0,b}; LH {{16{h[15]}},h}; LHU {16'b0,h}; LW rdata.
//  - Write is visible the cycle after rvalid; WB is back in IDLE (rdy=1) in that same cycle.
//  rvalid in IDLE without a same-cycle load accept sets err_spurious (sticky until reset); the data is ignored.
//  Throughput: 1 NOP per cycle; a load occupies >=1 cycle. No more than one load is ever outstanding.
//  rf_wen is 0 in every cycle not listed above; rf_waddr/rf_wdata hold their last value.
// TESTING
//  1 NOP x5 back-to-back, rsd=1..5, data=i*0x11 -> rf_wen 5 consecutive cycles, waddr 1..5, wdata 0x11..0x55.
//  2 LB baddr=2, rsd=7, rvalid 3 cycles later, rdata=0x12_80_34_56 -> wb_pend_vld=1 for 3 cycles, then rf_wdata=0xFFFFFF80, waddr=7; LBU same -> 0x00000080.
//  3 LHU baddr=2, rvalid same cycle as accept, rdata=0xBEEF1234 -> no WAIT, rf_wdata=0x0000BEEF next cycle; LH -> 0xFFFFBEEF.
//  4 LW with no response -> err_timeout pulse on cycle TIMEOUT after accept, rf_wen stays 0, rdy=1 afterwards; repeat with rvalid at cnt=TIMEOUT-1 -> normal write, no error.
//  5 LW baddr=1 -> err_misalign pulse, no write, no WAIT; then rvalid -> err_spurious=1 and stays set.
//  6 LW accepted, rstn asserted in WAIT, rvalid after release -> outputs reset, no rf write, err_spurious=1; LD rsd=0 -> waits for response, rf_wen stays 0.

Source files
------------

// File: rtl/riscv_wb.sv
// Writeback stage: retires ALU results directly and completes loads from the
// data-bus read response, with load alignment/extension and error reporting.
module riscv_wb #(
  parameter int unsigned LD_FUNCT_W = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_wb_vld,
  output logic                  mem_wb_rdy,
  input  logic [LD_FUNCT_W-1:0] mem_wb_funct,
  input  logic [1:0]            mem_wb_baddr,
  input  logic [31:0]           mem_wb_data,
  input  logic [4:0]            mem_wb_rsd,
  input  logic                  data_bif_rvalid,
  input  logic [31:0]           data_bif_rdata,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  wb_pend_vld,
  output logic [4:0]            wb_pend_rsd,
  output logic                  err_misalign,
  output logic                  err_timeout,
  output logic                  err_spurious
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [LD_FUNCT_W-1:0] F_LB  = LD_FUNCT_W'(1);
  localparam logic [LD_FUNCT_W-1:0] F_LH  = LD_FUNCT_W'(2);
  localparam logic [LD_FUNCT_W-1:0] F_LW  = LD_FUNCT_W'(3);
  localparam logic [LD_FUNCT_W-1:0] F_LBU = LD_FUNCT_W'(4);
  localparam logic [LD_FUNCT_W-1:0] F_LHU = LD_FUNCT_W'(5);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [LD_FUNCT_W-1:0] r_funct;
  logic [1:0]            r_baddr;
  logic [4:0]            r_rsd;
  logic                  r_wen, w_wen_nxt;
  logic [4:0]            r_waddr, w_waddr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic                  r_mis, w_mis_nxt;
  logic                  r_to, w_to_nxt;
  logic                  r_spur, w_spur_nxt;
  logic                  w_latch;
  logic                  w_accept, w_is_load, w_misalign;
  logic [LD_FUNCT_W-1:0] w_sel_funct;
  logic [1:0]            w_sel_baddr;
  logic [4:0]            w_sel_rsd;
  logic [31:0]           w_shift_b, w_shift_h, w_ld_data;

  assign mem_wb_rdy   = (r_state == S_IDLE);
  assign wb_pend_vld  = (r_state == S_WAIT);
  assign wb_pend_rsd  = (r_state == S_WAIT) ? r_rsd : '0;
  assign rf_wen       = r_wen;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign err_misalign = r_mis;
  assign err_timeout  = r_to;
  assign err_spurious = r_spur;

  assign w_accept   = mem_wb_vld & (r_state == S_IDLE);
  assign w_is_load  = (mem_wb_funct >= F_LB) && (mem_wb_funct <= F_LHU);
  assign w_misalign = (((mem_wb_funct == F_LH) || (mem_wb_funct == F_LHU)) && mem_wb_baddr[0]) ||
                      ((mem_wb_funct == F_LW) && (mem_wb_baddr != 2'b00));

  // A same-cycle response in IDLE completes using the live inputs, not the latched copy.
  always_comb begin
    w_sel_funct = (r_state == S_IDLE) ? mem_wb_funct : r_funct;
    w_sel_baddr = (r_state == S_IDLE) ? mem_wb_baddr : r_baddr;
    w_sel_rsd   = (r_state == S_IDLE) ? mem_wb_rsd   : r_rsd;
    w_shift_b   = data_bif_rdata >> {w_sel_baddr, 3'b000};
    w_shift_h   = data_bif_rdata >> {w_sel_baddr[1], 4'b0000};
    case (w_sel_funct)
      F_LB:    w_ld_data = {{24{w_shift_b[7]}}, w_shift_b[7:0]};
      F_LBU:   w_ld_data = {24'b0, w_shift_b[7:0]};
      F_LH:    w_ld_data = {{16{w_shift_h[15]}}, w_shift_h[15:0]};
      F_LHU:   w_ld_data = {16'b0, w_shift_h[15:0]};
      default: w_ld_data = data_bif_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wen_nxt   = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_mis_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    w_spur_nxt  = r_spur;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_load) begin
            w_wen_nxt   = (mem_wb_rsd != 5'd0);
            w_waddr_nxt = mem_wb_rsd;
            w_wdata_nxt = mem_wb_data;
          end else if (w_misalign) begin
            w_mis_nxt = 1'b1;
          end else if (data_bif_rvalid) begin
            w_wen_nxt   = (w_sel_rsd != 5'd0);
            w_waddr_nxt = w_sel_rsd;
            w_wdata_nxt = w_ld_data;
          end else begin
            w_latch     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
          end
        end
        if (data_bif_rvalid && !(w_accept && w_is_load && !w_misalign))
          w_spur_nxt = 1'b1;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (data_bif_rvalid) begin
          w_wen_nxt   = (w_sel_rsd != 5'd0);
          w_waddr_nxt = w_sel_rsd;
          w_wdata_nxt = w_ld_data;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_to_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_funct <= '0;
      r_baddr <= '0;
      r_rsd   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wen   <= w_wen_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_mis   <= w_mis_nxt;
      r_to    <= w_to_nxt;
      r_spur  <= w_spur_nxt;
      if (w_latch) begin
        r_funct <= mem_wb_funct;
        r_baddr <= mem_wb_baddr;
        r_rsd   <= mem_wb_rsd;
      end
    end
  end

endmodule
